// File: rtl/fc_relu_stream.sv
// fc_relu_stream: arithmetic right shift plus optional ReLU on an fc output stream, buffered in a D-entry FIFO.
// Define FC_RELU_STREAM_RELU_EN to clamp negative samples to zero; without it the activation is the identity.
module fc_relu_stream #(
    parameter int T     = 16,
    parameter int M     = 16,
    parameter int D     = 4,
    parameter int SHIFT = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         input_valid,
    output logic         input_ready,
    input  logic [T-1:0] input_data,
    output logic         output_valid,
    input  logic         output_ready,
    output logic [T-1:0] output_data,
    output logic         output_last
);

    localparam int AW = (D > 1) ? $clog2(D) : 1;
    localparam int CW = $clog2(D + 1);
    localparam int IW = (M > 1) ? $clog2(M) : 1;

    logic [T-1:0]        mem [D];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [CW-1:0]       count;
    logic [IW-1:0]       idx;
    logic signed [T-1:0] shifted;
    logic [T-1:0]        processed;
    logic                push;
    logic                pop;

    assign shifted = $signed(input_data) >>> SHIFT;

`ifdef FC_RELU_STREAM_RELU_EN
    assign processed = shifted[T-1] ? '0 : shifted;
`else
    assign processed = shifted;
`endif

    // Handshake flags depend only on the registered count, never on the other side's inputs.
    assign input_ready  = (count < CW'(D));
    assign output_valid = (count != '0);
    assign output_data  = mem[rd_ptr];
    assign output_last  = output_valid && (idx == IW'(M - 1));

    assign push = input_valid && input_ready;
    assign pop  = output_valid && output_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= processed;
        end
    end

    // D is a power of two, so the pointers wrap modulo D on natural overflow.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            idx    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                idx    <= (idx == IW'(M - 1)) ? '0 : idx + IW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_relu_stream.sv
// Self-checking bench for fc_relu_stream: constant vector table, hand-built corner sequences,
// and randomized streams checked against a queue-based reference model.
module tb_fc_relu_stream;

    localparam int T     = 16;
    localparam int M     = 16;
    localparam int D     = 4;
    localparam int SHIFT = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         input_valid;
    logic         input_ready;
    logic [T-1:0] input_data;
    logic         output_valid;
    logic         output_ready;
    logic [T-1:0] output_data;
    logic         output_last;

    int vectors    = 0;
    int miscompares = 0;
    int model_q[$];
    int delivered  = 0;
    int pushed     = 0;

    typedef struct {
        int din;
        int expected;
    } vec_t;

    fc_relu_stream #(.T(T), .M(M), .D(D), .SHIFT(SHIFT)) dut (
        .clk          (clk),
        .reset        (reset),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .input_data   (input_data),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .output_data  (output_data),
        .output_last  (output_last)
    );

    always #5 clk = ~clk;

    // Floor division by 2**SHIFT, then the activation chosen by the build.
    function automatic int model_proc(input int x);
        int div;
        int s;
        div = 1 << SHIFT;
        if (x >= 0) s = x / div;
        else        s = -((-x + div - 1) / div);
`ifdef FC_RELU_STREAM_RELU_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    task automatic check_output(input string name, input logic signed [31:0] actual,
                                input logic signed [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic apply_stimulus(input logic iv, input int din, input logic ordy);
        logic [31:0] dbits;
        bit do_push;
        bit do_pop;
        dbits        = din;
        input_valid  = iv;
        input_data   = dbits[T-1:0];
        output_ready = ordy;
        check_output("input_ready", input_ready, model_q.size() < D);
        check_output("output_valid", output_valid, model_q.size() > 0);
        if (model_q.size() > 0) begin
            check_output("output_data", $signed(output_data), model_q[0]);
            check_output("output_last", output_last, (delivered % M) == M - 1);
        end
        do_push = iv && (model_q.size() < D);
        do_pop  = ordy && (model_q.size() > 0);
        @(posedge clk);
        if (do_pop) begin
            void'(model_q.pop_front());
            delivered++;
        end
        if (do_push) begin
            model_q.push_back(model_proc(din));
            pushed++;
        end
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b0;
        input_valid  = 1'b0;
        output_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_q.delete();
        delivered = 0;
        pushed    = 0;
    endtask

    function automatic int rand_sample();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic drain();
        for (int i = 0; i < 2 * D && model_q.size() > 0; i++) begin
            apply_stimulus(1'b0, 0, 1'b1);
        end
        check_output("drain_empty", model_q.size(), 0);
    endtask

    // Random valid/ready stream of n samples with a bounded cycle budget.
    task automatic stream_samples(input int n, input int budget);
        int target_push;
        int target_del;
        int cycles;
        target_push = pushed + n;
        target_del  = delivered + n;
        cycles      = 0;
        while (delivered < target_del && cycles < budget) begin
            apply_stimulus((pushed < target_push) && ($urandom_range(0, 3) != 0),
                           rand_sample(), $urandom_range(0, 2) != 0);
            cycles++;
        end
        check_output("stream_delivered", delivered, target_del);
    endtask

    initial begin
        vec_t vecs[8];
        int   ready_cycles;

`ifdef FC_RELU_STREAM_RELU_EN
        vecs[0] = '{-102, 0};
        vecs[1] = '{119, 29};
        vecs[2] = '{-1, 0};
        vecs[3] = '{4, 1};
        vecs[4] = '{3, 0};
        vecs[5] = '{32767, 8191};
        vecs[6] = '{-32768, 0};
        vecs[7] = '{-5, 0};
`else
        vecs[0] = '{-102, -26};
        vecs[1] = '{119, 29};
        vecs[2] = '{-1, -1};
        vecs[3] = '{4, 1};
        vecs[4] = '{3, 0};
        vecs[5] = '{32767, 8191};
        vecs[6] = '{-32768, -8192};
        vecs[7] = '{-5, -2};
`endif

        reset        = 1'b0;
        input_valid  = 1'b0;
        input_data   = '0;
        output_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        check_output("reset_input_ready", input_ready, 1);
        check_output("reset_output_valid", output_valid, 0);
        check_output("reset_output_last", output_last, 0);

        // Single push then pop: value visible one cycle after its input transfer.
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b1, vecs[i].din, 1'b0);
            check_output("table_valid", output_valid, 1);
            check_output("table_data", $signed(output_data), vecs[i].expected);
            apply_stimulus(1'b0, 0, 1'b1);
        end

        // Fill to full with output stalled, then one pop frees a slot.
        do_reset();
        ready_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            if (input_ready === 1'b1) ready_cycles++;
            apply_stimulus(1'b1, rand_sample(), 1'b0);
        end
        check_output("full_transfers", ready_cycles, D);
        check_output("full_input_ready", input_ready, 0);
        apply_stimulus(1'b0, 0, 1'b1);
        check_output("after_pop_input_ready", input_ready, 1);
        drain();

        // Steady push and pop with two samples in flight.
        do_reset();
        apply_stimulus(1'b1, rand_sample(), 1'b0);
        apply_stimulus(1'b1, rand_sample(), 1'b0);
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1'b1, rand_sample(), 1'b1);
        end
        check_output("steady_occupancy", model_q.size(), 2);
        drain();

        // Two full vectors with random stalls on both sides.
        do_reset();
        stream_samples(2 * M, 2000);
        drain();

        // Reset mid-vector with two samples buffered.
        do_reset();
        apply_stimulus(1'b1, rand_sample(), 1'b0);
        apply_stimulus(1'b1, rand_sample(), 1'b0);
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b1, rand_sample(), 1'b1);
        end
        check_output("pre_reset_delivered", delivered, 5);
        check_output("pre_reset_valid", output_valid, 1);
        do_reset();
        check_output("mid_reset_output_valid", output_valid, 0);
        check_output("mid_reset_input_ready", input_ready, 1);
        check_output("mid_reset_output_last", output_last, 0);
        stream_samples(M, 1000);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
